// File: rtl/mem_wb_stage.sv
// EX/MEM latch, data-cache access controller and MEM/WB latch for the pipeline back end.
// Optional `MEM_STALL_CNT_EN adds a free-running count of mem_busy cycles on stall_cycles.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WEN,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluout,
    input  logic [DATA_W-1:0] ex_storedata,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwen,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_halt,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [DATA_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_busy,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_halt
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic              r_m_valid;
    logic              r_m_regwen;
    logic              r_m_memread;
    logic              r_m_memwrite;
    logic              r_m_store;
    logic              r_m_halt;
    logic [DATA_W-1:0] r_m_aluout;
    logic [DATA_W-1:0] r_m_storedata;
    logic [REG_AW-1:0] r_m_rd;
    logic [DATA_W-1:0] r_hold;

    logic              r_wb_valid;
    logic              r_wb_wen;
    logic              r_wb_halt;
    logic [REG_AW-1:0] r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_access;
    logic              w_busy;
    logic              w_adv;
    logic              w_mem_ok;
    logic              w_ex_memop;
    logic [DATA_W-1:0] w_load_data;

    assign w_access    = (r_state == S_ACCESS);
    assign w_busy      = w_access & ~dhit;
    assign w_adv       = WEN & ~w_busy;
    // Nothing behind a halt (already retired or still sitting in M) may touch memory.
    assign w_mem_ok    = ex_valid & ~ex_halt & ~r_wb_halt & ~(r_m_valid & r_m_halt);
    assign w_ex_memop  = w_mem_ok & (ex_memread | ex_memwrite);
    assign w_load_data = w_access ? dmemload : r_hold;

    always_comb begin
        w_state_nxt = r_state;
        if (w_adv && !flush && w_ex_memop) begin
            w_state_nxt = S_ACCESS;
        end else if (w_adv) begin
            w_state_nxt = S_IDLE;
        end else if (w_access && dhit) begin
            w_state_nxt = S_DONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_m_valid     <= 1'b0;
            r_m_regwen    <= 1'b0;
            r_m_memread   <= 1'b0;
            r_m_memwrite  <= 1'b0;
            r_m_store     <= 1'b0;
            r_m_halt      <= 1'b0;
            r_m_aluout    <= '0;
            r_m_storedata <= '0;
            r_m_rd        <= '0;
        end else if (w_adv) begin
            if (flush) begin
                r_m_valid    <= 1'b0;
                r_m_memread  <= 1'b0;
                r_m_memwrite <= 1'b0;
                r_m_halt     <= 1'b0;
            end else begin
                r_m_valid     <= ex_valid;
                r_m_regwen    <= ex_regwen;
                r_m_memread   <= ex_memread & w_mem_ok;
                r_m_memwrite  <= ex_memwrite & w_mem_ok;
                r_m_store     <= ex_memwrite;
                r_m_halt      <= ex_halt;
                r_m_aluout    <= ex_aluout;
                r_m_storedata <= ex_storedata;
                r_m_rd        <= ex_rd;
            end
        end
    end

    // A hit taken while the pipe is stalled is parked here until the next advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold <= '0;
        end else if (w_access && dhit && !WEN) begin
            r_hold <= dmemload;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wb_valid <= 1'b0;
            r_wb_wen   <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_halt  <= 1'b0;
        end else if (w_adv) begin
            r_wb_valid <= r_m_valid;
            r_wb_wen   <= r_m_valid & r_m_regwen & ~r_m_store;
            r_wb_rd    <= r_m_rd;
            r_wb_data  <= r_m_memread ? w_load_data : r_m_aluout;
            if (r_m_valid && r_m_halt) begin
                r_wb_halt <= 1'b1;
            end
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_busy) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

    assign dmemREN   = w_access & r_m_memread;
    assign dmemWEN   = w_access & r_m_memwrite;
    assign dmemaddr  = r_m_aluout;
    assign dmemstore = r_m_storedata;
    assign mem_busy  = w_busy;
    assign wb_valid  = r_wb_valid;
    assign wb_wen    = r_wb_wen;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign wb_halt   = r_wb_halt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic checked against a
// transaction-level model (slot contents + "request served" flag + expected writeback).
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RST, WEN, flush, ex_valid, ex_regwen, ex_memread, ex_memwrite, ex_halt, dhit;
    logic [31:0] ex_aluout, ex_storedata, dmemload;
    logic [4:0]  ex_rd;
    logic        dmemREN, dmemWEN, mem_busy, wb_valid, wb_wen, wb_halt;
    logic [31:0] dmemaddr, dmemstore, wb_data;
    logic [4:0]  wb_rd;
`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST(RST), .WEN(WEN), .flush(flush),
        .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_storedata(ex_storedata),
        .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_halt(ex_halt),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_halt(wb_halt)
`ifdef MEM_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // Reference model: what instruction sits between EX and WB, whether its memory
    // access still needs serving, and what the writeback bundle should be.
    bit          m_v, m_pending, m_load, m_storeop, m_wr_raw, m_regwen, m_halt, served;
    logic [31:0] m_addr, m_sd, held;
    logic [4:0]  m_rd;
    bit          e_wv, e_wen, e_halt;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_pending = 0; m_load = 0; m_storeop = 0; m_wr_raw = 0;
        m_regwen = 0; m_halt = 0; served = 0;
        m_addr = '0; m_sd = '0; held = '0; m_rd = '0;
        e_wv = 0; e_wen = 0; e_halt = 0; e_rd = '0; e_data = '0; e_stall = '0;
    endtask

    task automatic idle();
        RST = 0; WEN = 1; flush = 0; ex_valid = 0; ex_regwen = 0;
        ex_memread = 0; ex_memwrite = 0; ex_halt = 0; dhit = 0;
        ex_aluout = '0; ex_storedata = '0; ex_rd = '0; dmemload = $urandom;
    endtask

    task automatic rnd(input bit allow_rst);
        int op;
        RST = allow_rst && ($urandom_range(0, 39) == 0);
        WEN = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 7) == 0);
        ex_valid = ($urandom_range(0, 4) != 0);
        op = $urandom_range(0, 3);
        ex_memread = (op == 1) || (op == 3);
        ex_memwrite = (op == 2);
        ex_regwen = $urandom_range(0, 1);
        ex_halt = 0;
        ex_aluout = $urandom; ex_storedata = $urandom; ex_rd = 5'($urandom);
        dhit = ($urandom_range(0, 2) == 0);
        dmemload = $urandom;
    endtask

    // One clock: check request-side outputs against current inputs, advance the model
    // with the inputs sampled at the edge, then check the writeback side.
    task automatic tick();
        bit acc, busy, adv, memop;
        #1;
        acc  = m_pending && !served;
        busy = acc && !dhit;
        chk("mem_busy", 32'(mem_busy), 32'(busy));
        chk("dmemREN", 32'(dmemREN), 32'(acc && m_load));
        chk("dmemWEN", 32'(dmemWEN), 32'(acc && m_storeop));
        if (acc) begin
            chk("dmemaddr", dmemaddr, m_addr);
            chk("dmemstore", dmemstore, m_sd);
        end
        @(posedge CLK);
        adv = WEN && !busy;
        if (RST) begin
            model_reset();
        end else begin
            if (busy) e_stall = e_stall + 32'd1;
            if (adv) begin
                memop = ex_valid && (ex_memread || ex_memwrite) && !ex_halt
                        && !e_halt && !(m_v && m_halt);
                e_wv  = m_v;
                e_rd  = m_rd;
                e_wen = m_v && m_regwen && !m_wr_raw;
                e_data = m_load ? (served ? held : dmemload) : m_addr;
                if (m_v && m_halt) e_halt = 1;
                if (flush) begin
                    m_v = 0; m_pending = 0; m_load = 0; m_storeop = 0; m_halt = 0;
                end else begin
                    m_v = ex_valid; m_pending = memop;
                    m_load = memop && ex_memread; m_storeop = memop && ex_memwrite;
                    m_wr_raw = ex_memwrite; m_regwen = ex_regwen; m_halt = ex_halt;
                    m_addr = ex_aluout; m_sd = ex_storedata; m_rd = ex_rd;
                end
                served = 0;
            end else if (acc && dhit) begin
                served = 1;
                held = dmemload;
            end
        end
        #1;
        chk("wb_valid", 32'(wb_valid), 32'(e_wv));
        chk("wb_wen", 32'(wb_wen), 32'(e_wen));
        chk("wb_halt", 32'(wb_halt), 32'(e_halt));
        if (e_wv) begin
            chk("wb_rd", 32'(wb_rd), 32'(e_rd));
            chk("wb_data", wb_data, e_data);
        end
`ifdef MEM_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, e_stall);
`endif
        #1;
    endtask

    initial begin
        model_reset();

        // Reset held two cycles under random inputs
        rnd(0); RST = 1; tick();
        rnd(0); RST = 1; tick();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_dmemREN", 32'(dmemREN), 32'd0);
        chk("rst_dmemaddr", dmemaddr, 32'd0);

        // Plain ALU op
        idle(); ex_valid = 1; ex_aluout = 32'h1234; ex_rd = 5'd5; ex_regwen = 1; tick();
        idle(); tick();
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", 32'(wb_rd), 32'd5);
        chk("alu_wb_wen", 32'(wb_wen), 32'd1);

        // Load missing for two cycles, hitting on the third
        idle(); ex_valid = 1; ex_memread = 1; ex_aluout = 32'h40; ex_rd = 5'd7; ex_regwen = 1; tick();
        chk("ld_ren", 32'(dmemREN), 32'd1);
        chk("ld_addr", dmemaddr, 32'h40);
        idle(); tick();
        idle(); tick();
        idle(); dhit = 1; dmemload = 32'hDEADBEEF; tick();
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_wen", 32'(wb_wen), 32'd1);

        // Hit while stalled: data parked, request not reissued
        idle(); ex_valid = 1; ex_memread = 1; ex_aluout = 32'h44; ex_rd = 5'd8; ex_regwen = 1; tick();
        idle(); WEN = 0; dhit = 1; dmemload = 32'hA5A5A5A5; tick();
        idle(); WEN = 0; tick();
        idle(); WEN = 0; tick();
        chk("hold_no_reissue", 32'(dmemREN), 32'd0);
        chk("hold_not_busy", 32'(mem_busy), 32'd0);
        idle(); tick();
        chk("hold_wb_data", wb_data, 32'hA5A5A5A5);

        // Store, then flush a following instruction
        idle(); ex_valid = 1; ex_memwrite = 1; ex_aluout = 32'h80; ex_storedata = 32'h77;
        ex_rd = 5'd9; ex_regwen = 1; tick();
        chk("st_wen", 32'(dmemWEN), 32'd1);
        chk("st_data", dmemstore, 32'h77);
        idle(); ex_valid = 1; ex_aluout = 32'h55; ex_rd = 5'd3; ex_regwen = 1; dhit = 1; tick();
        chk("st_wb_wen", 32'(wb_wen), 32'd0);
        chk("st_wb_valid", 32'(wb_valid), 32'd1);
        idle(); ex_valid = 1; ex_aluout = 32'h99; ex_rd = 5'd4; ex_regwen = 1; flush = 1; tick();
        idle(); tick();
        chk("flush_wb_valid", 32'(wb_valid), 32'd0);

        // Random traffic
        repeat (400) begin
            rnd(1); tick();
        end

        // Halt is sticky and blocks later memory ops
        idle(); RST = 1; tick();
        idle(); ex_valid = 1; ex_halt = 1; tick();
        idle(); tick();
        chk("halt_set", 32'(wb_halt), 32'd1);
        repeat (20) begin
            rnd(0); tick();
        end
        chk("halt_sticky", 32'(wb_halt), 32'd1);

        // Reset in the middle of an outstanding load
        idle(); RST = 1; tick();
        idle(); ex_valid = 1; ex_memread = 1; ex_aluout = 32'hC0; ex_rd = 5'd2; ex_regwen = 1; tick();
        chk("mid_ren_before", 32'(dmemREN), 32'd1);
        idle(); RST = 1; tick();
        chk("mid_rst_ren", 32'(dmemREN), 32'd0);
        chk("mid_rst_busy", 32'(mem_busy), 32'd0);
        idle(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the pipeline register interface: EX/MEM latch, memory-access controller, and MEM/WB latch in one block.
- Captures EX results when the hazard unit's WEN permits.
- Drives the datapath dcache request (dmemREN/dmemWEN) until dhit.
- Presents a writeback bundle to the register file.
- Reports mem_busy back to the hazard unit.

Parameters:
DATA_W, 32, datapath word width
REG_AW, 5, register-file address width

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
WEN  in  1  pipeline advance enable from hazard unit
flush  in  1  load a bubble into EX/MEM instead of EX data
ex_valid  in  1  EX holds a real instruction
ex_aluout  in  DATA_W  ALU result / memory address
ex_storedata  in  DATA_W  store data
ex_rd  in  REG_AW  destination register
ex_regwen  in  1  instruction writes rd
ex_memread  in  1  load
ex_memwrite  in  1  store
ex_halt  in  1  halt instruction
dhit  in  1  dcache completes current request
dmemload  in  DATA_W  load data (valid with dhit)
dmemREN  out  1  dcache read request
dmemWEN  out  1  dcache write request
dmemaddr  out  DATA_W  request address
dmemstore  out  DATA_W  store data
mem_busy  out  1  EX/MEM cannot advance
wb_valid  out  1  MEM/WB holds a real instruction
wb_wen  out  1  register write enable (wb_valid & regwen)
wb_rd  out  REG_AW  writeback register
wb_data  out  DATA_W  writeback value
wb_halt  out  1  sticky halt

Behaviour:
- Reset: all latches clear. wb_valid=0, wb_wen=0, wb_rd=0, wb_data=0, wb_halt=0. FSM=IDLE. dmemREN=dmemWEN=0, dmemaddr=0, dmemstore=0, mem_busy=0.
- adv = WEN & ~mem_busy. Both latches update only on adv; otherwise they hold.
- EX/MEM latch (M):
  - On adv with flush=1: M.valid=0; other fields don't-care.
  - On adv with flush=0: M captures all ex_* fields.
- FSM states:
  - IDLE: M has no memory operation.
  - ACCESS: request outstanding.
  - DONE: hit already taken, waiting for adv.
- FSM next-state, evaluated at each edge:
  - If adv loads a valid mem op (ex_memread|ex_memwrite, flush=0): next=ACCESS.
  - Else if adv: next=IDLE.
  - Else if ACCESS & dhit: next=DONE.
  - Else: hold.
- Request outputs:
  - dmemREN = (state==ACCESS) & M.memread.
  - dmemWEN = (state==ACCESS) & M.memwrite.
  - dmemaddr = M.aluout; dmemstore = M.storedata. Both stable throughout ACCESS.
- mem_busy = (state==ACCESS) & ~dhit. This is combinational, so a hit with WEN=1 advances in the same cycle. Latency for a hitting load is one cycle in M.
- Load data capture:
  - ACCESS & dhit & ~WEN: dmemload is captured into a hold register and the state moves to DONE.
  - DONE: no request is reissued, mem_busy=0, and the held data is used on the later adv.
- MEM/WB load on adv:
  - wb_valid = M.valid.
  - wb_rd = M.rd.
  - wb_wen = M.valid & M.regwen.
  - wb_data = the load value if M.memread (dmemload if ACCESS, held value if DONE), else M.aluout.
- A store never sets wb_wen, regardless of regwen.
- Halt: on adv with M.valid & M.halt, wb_halt is set and stays 1 until RST. After halt, no new memory requests are issued; a halt in M is never a mem op.
- Simultaneous WEN=1 and flush=1 while ACCESS & ~dhit: mem_busy blocks adv, the flush is ignored, and the hazard unit reasserts it.
- RST asserted mid-ACCESS: FSM goes to IDLE and requests drop the next cycle. The block does not wait for dhit.
- Bubble in M (valid=0): FSM stays IDLE and no request is issued, even if the memread bit is stale.

Optional Feature:
- Macro MEM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0].
  - Increments every cycle mem_busy=1 and wraps at 2^32-1 -> 0.
  - Cleared by RST.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RST 2 cycles with random inputs -> all outputs 0, FSM IDLE.
- ALU op: ex_aluout=0x1234, rd=5, regwen=1, WEN=1 for 2 cycles -> wb_data=0x1234, wb_rd=5, wb_wen=1, no dmem request.
- Load with 3-cycle miss: addr=0x40, dhit on 3rd ACCESS cycle with dmemload=0xDEADBEEF -> dmemREN=1 for 3 cycles, mem_busy=1 for 2 cycles, next cycle wb_data=0xDEADBEEF, wb_wen=1.
- Hit while WEN=0: dhit with dmemload=0xA5A5A5A5, WEN low 2 more cycles -> dmemREN drops after the hit, no reissue, wb_data=0xA5A5A5A5 when WEN returns.
- Store then flush: store to 0x80 data 0x77 -> dmemWEN=1, wb_wen=0. Then flush=1 with WEN=1 -> wb_valid=0 next cycle.
- Halt plus reset mid-access: halt propagates -> wb_halt=1 sticky. Separately, RST during ACCESS -> dmemREN=0 next cycle. With MEM_STALL_CNT_EN defined, stall_cycles counts exactly the mem_busy cycles.
